tx_frame_scheduler: RTL

- Sits between the 512-deep sample buffer and uart_tx and sequences all buffer readout.
- Replaces the free-running read_en = tx_ready path with framed transmission: SYNC byte, LEN byte, LEN payload bytes, XOR checksum.
- Launches a frame when MAX_PAYLOAD bytes are buffered, or on an idle timeout when fewer are buffered, so the host can resynchronise on the link.

---
 rtl/tx_frame_pkg.sv | 41 ++++
 rtl/tx_frame_scheduler_buf_fill_timer.sv | 52 +++++
 rtl/tx_frame_scheduler.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_pkg.sv
// Shared state type, frame constants and buffer fill-level helper for tx_frame_scheduler.
// FRAME_OVERHEAD follows the optional sequence byte (macro TX_FRAME_SEQ_EN).
package tx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    LEN     = 3'd2,
    SEQ     = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5,
    PAY     = 3'd6,
    CHK     = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

`ifdef TX_FRAME_SEQ_EN
  localparam int FRAME_OVERHEAD = 4;
`else
  localparam int FRAME_OVERHEAD = 3;
`endif

  // Pointers arrive zero-extended; depth must be a power of two so the mask gives the modulo.
  function automatic logic [16:0] fill_level(input logic [15:0] wr_ptr,
                                             input logic [15:0] rd_ptr,
                                             input logic        empty,
                                             input logic        full,
                                             input logic [16:0] depth);
    logic [16:0] diff;
    diff = ({1'b0, wr_ptr} - {1'b0, rd_ptr}) & (depth - 17'd1);
    if (full) begin
      fill_level = depth;
    end else if (empty) begin
      fill_level = 17'd0;
    end else begin
      fill_level = diff;
    end
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_buf_fill_timer.sv
// Buffer fill level plus the saturating idle timer that triggers partial frames.
module buf_fill_timer
  import tx_frame_pkg::*;
#(
  parameter int DEPTH          = 512,
  parameter int ADDR_WIDTH     = 9,
  parameter int MAX_PAYLOAD    = 64,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wr_ptr,
  input  logic [ADDR_WIDTH-1:0] rd_ptr,
  input  logic                  empty,
  input  logic                  full,
  input  logic                  idle,
  input  logic                  frame_start,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  timeout_hit
);

  localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
  localparam logic [16:0]     MAX_LEVEL   = 17'(MAX_PAYLOAD);

  logic [16:0]   level_s;
  logic          clear_s;
  logic [TW-1:0] timer_r;

  // Fill level and timer clear condition.
  always_comb begin
    level_s = fill_level(16'(wr_ptr), 16'(rd_ptr), empty, full, 17'(DEPTH));
    count   = level_s[ADDR_WIDTH:0];
    clear_s = !idle || frame_start || (level_s == 17'd0) || (level_s >= MAX_LEVEL);
  end

  // Idle timer, saturating at the timeout value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= {TW{1'b0}};
    end else if (clear_s) begin
      timer_r <= {TW{1'b0}};
    end else if (timer_r != TIMEOUT_VAL) begin
      timer_r <= timer_r + 1'b1;
    end else begin
      timer_r <= timer_r;
    end
  end

  assign timeout_hit = (timer_r == TIMEOUT_VAL);

endmodule

// File: rtl/tx_frame_scheduler.sv
// Framed UART readout of the sample buffer: SYNC, LEN, [SEQ], payload, XOR checksum.
// Optional sequence byte after LEN when TX_FRAME_SEQ_EN is defined.
module tx_frame_scheduler
  import tx_frame_pkg::*;
#(
  parameter int         DEPTH          = 512,
  parameter int         ADDR_WIDTH     = 9,
  parameter int         MAX_PAYLOAD    = 64,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] buf_wr_ptr,
  input  logic [ADDR_WIDTH-1:0] buf_rd_ptr,
  input  logic                  buf_empty,
  input  logic                  buf_full,
  output logic                  buf_rd_en,
  input  logic [7:0]            buf_data,
  input  logic                  buf_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  localparam logic [ADDR_WIDTH:0] MAX_CNT  = (ADDR_WIDTH + 1)'(MAX_PAYLOAD);
  localparam logic [ADDR_WIDTH:0] ZERO_CNT = {(ADDR_WIDTH + 1){1'b0}};
  localparam logic [7:0]          MAX_LEN  = 8'(MAX_PAYLOAD);

  state_t              state_r, state_n;
  logic [7:0]          len_r, len_n, rem_r, rem_n, chk_r, chk_n;
  logic [7:0]          tx_data_n, launch_len_s;
  logic                tx_valid_n, rd_en_n, busy_n;
  logic [15:0]         frame_count_n;
  logic                launch_s, frame_start_s, xfer_s, timeout_hit_s;
  logic [ADDR_WIDTH:0] count_s;
`ifdef TX_FRAME_SEQ_EN
  logic [7:0]          seq_r, seq_n;
`endif

  buf_fill_timer #(
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .MAX_PAYLOAD    (MAX_PAYLOAD),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fill (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_ptr      (buf_wr_ptr),
    .rd_ptr      (buf_rd_ptr),
    .empty       (buf_empty),
    .full        (buf_full),
    .idle        (state_r == IDLE),
    .frame_start (frame_start_s),
    .count       (count_s),
    .timeout_hit (timeout_hit_s)
  );

  assign xfer_s = tx_valid && tx_ready;

  // Launch decision: a full payload, or a partial one once the idle timer expires.
  always_comb begin
    if (count_s >= MAX_CNT) begin
      launch_s     = enable;
      launch_len_s = MAX_LEN;
    end else if ((count_s != ZERO_CNT) && timeout_hit_s) begin
      launch_s     = enable;
      launch_len_s = count_s[7:0];
    end else begin
      launch_s     = 1'b0;
      launch_len_s = MAX_LEN;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n       = state_r;
    len_n         = len_r;
    rem_n         = rem_r;
    chk_n         = chk_r;
    tx_data_n     = tx_data;
    tx_valid_n    = tx_valid;
    rd_en_n       = 1'b0;
    busy_n        = busy;
    frame_count_n = frame_count;
    frame_start_s = 1'b0;
`ifdef TX_FRAME_SEQ_EN
    seq_n         = seq_r;
`endif
    case (state_r)
      IDLE: begin
        if (launch_s) begin
          state_n       = SYNC;
          len_n         = launch_len_s;
          rem_n         = launch_len_s;
          tx_data_n     = SYNC_BYTE;
          tx_valid_n    = 1'b1;
          busy_n        = 1'b1;
          frame_start_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      SYNC: begin
        if (xfer_s) begin
          state_n   = LEN;
          tx_data_n = len_r;
          chk_n     = len_r;
        end else begin
          state_n = SYNC;
        end
      end
      LEN: begin
        if (xfer_s) begin
`ifdef TX_FRAME_SEQ_EN
          state_n   = SEQ;
          tx_data_n = seq_r;
          chk_n     = chk_r ^ seq_r;
`else
          state_n    = RD_REQ;
          tx_valid_n = 1'b0;
          rd_en_n    = 1'b1;
`endif
        end else begin
          state_n = LEN;
        end
      end
`ifdef TX_FRAME_SEQ_EN
      SEQ: begin
        if (xfer_s) begin
          state_n    = RD_REQ;
          tx_valid_n = 1'b0;
          rd_en_n    = 1'b1;
        end else begin
          state_n = SEQ;
        end
      end
`endif
      RD_REQ: begin
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (buf_valid) begin
          state_n    = PAY;
          tx_data_n  = buf_data;
          tx_valid_n = 1'b1;
          chk_n      = chk_r ^ buf_data;
        end else begin
          state_n = RD_WAIT;
        end
      end
      PAY: begin
        if (xfer_s) begin
          rem_n = rem_r - 8'd1;
          if (rem_r == 8'd1) begin
            state_n   = CHK;
            tx_data_n = chk_r;
          end else begin
            state_n    = RD_REQ;
            tx_valid_n = 1'b0;
            rd_en_n    = 1'b1;
          end
        end else begin
          state_n = PAY;
        end
      end
      CHK: begin
        if (xfer_s) begin
          state_n       = IDLE;
          tx_valid_n    = 1'b0;
          busy_n        = 1'b0;
          frame_count_n = frame_count + 16'd1;
`ifdef TX_FRAME_SEQ_EN
          seq_n         = seq_r + 8'd1;
`endif
        end else begin
          state_n = CHK;
        end
      end
      default: begin
        state_n    = IDLE;
        tx_valid_n = 1'b0;
        busy_n     = 1'b0;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      len_r       <= 8'd0;
      rem_r       <= 8'd0;
      chk_r       <= 8'd0;
      tx_data     <= 8'd0;
      tx_valid    <= 1'b0;
      buf_rd_en   <= 1'b0;
      busy        <= 1'b0;
      frame_count <= 16'd0;
`ifdef TX_FRAME_SEQ_EN
      seq_r       <= 8'd0;
`endif
    end else begin
      state_r     <= state_n;
      len_r       <= len_n;
      rem_r       <= rem_n;
      chk_r       <= chk_n;
      tx_data     <= tx_data_n;
      tx_valid    <= tx_valid_n;
      buf_rd_en   <= rd_en_n;
      busy        <= busy_n;
      frame_count <= frame_count_n;
`ifdef TX_FRAME_SEQ_EN
      seq_r       <= seq_n;
`endif
    end
  end

endmodule
